ac_ctrl: RTL and testbench
==========================

# ac_ctrl

Sequencing controller for one accumulator (AC) instance. It accepts a stream of partial sums over a valid/ready handshake and drives the AC's `in_en` and `F` controls so that every `num_terms` consecutive psums fold into one output. Each result is presented over a valid/ready output handshake, and the result is held in the AC while downstream stalls. It sits between the PE-array psum output and the output buffer, and is configured once per layer tile.

## Interface
Parameters:
- `CNT_WIDTH`, default 16: width of the term and output counters.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `cfg_start`, in, 1: loads the configuration and starts a run; ignored while `busy`.
- `cfg_num_terms`, in, CNT_WIDTH: psums per output; 0 is treated as 1.
- `cfg_num_outputs`, in, CNT_WIDTH: outputs per run; 0 gives an immediate `done` with no transfers.
- `psum_valid`, in, 1: upstream psum present (data is wired directly to AC `ipsum`).
- `psum_ready`, out, 1: controller accepts a psum this cycle.
- `ac_in_en`, out, 1: drives AC `in_en`; equals `psum_valid & psum_ready` (combinational).
- `ac_F`, out, 1: drives AC `F`; registered.
- `out_valid`, out, 1: AC `data_out` holds a finished sum; registered.
- `out_ready`, in, 1: downstream accepts the result.
- `busy`, out, 1: run in progress.
- `done`, out, 1: one-cycle pulse after the final output handshake.

## Operation
- States: IDLE and RUN.
  - IDLE → RUN on `cfg_start`. This latches N = max(`cfg_num_terms`, 1) and M = `cfg_num_outputs`, and clears `term_cnt` and `out_cnt`.
  - If M = 0, the controller stays in IDLE and pulses `done` next cycle.
- Terminology: `accept` = `psum_valid & psum_ready`; `out_fire` = `out_valid & out_ready`.
- `psum_ready` is 1 in RUN when either:
  - `term_cnt` < N, or
  - `term_cnt` = N and `out_fire` (back-to-back: the first term of the next output is accepted in the same cycle as the previous result).
- `term_cnt` rules:
  - Increments on `accept`.
  - On `out_fire`, it becomes 1 if `accept` occurs that cycle, otherwise 0.
- `out_valid` rules:
  - Set at the edge where `accept` brings `term_cnt` to N.
  - Cleared on `out_fire` unless set again the same edge; setting again is only possible for N = 1.
- F sequencing, with two registers:
  - `first_d` <= `accept` & (`term_cnt` = 0, or the same-cycle `out_fire` restart).
  - `started` <= (`started` | `first_d`) & ~`out_fire`.
  - `ac_F` = `started`.
  - Net effect: F = 0 in the cycle the first term reaches AC's add node, and F = 1 afterwards. F = 1 during input gaps and output stalls holds `psum_reg` (ipsum_reg = 0).
- `out_cnt` increments on `out_fire`. When `out_fire` occurs with `out_cnt` = M−1:
  - Go to IDLE.
  - `psum_ready` is forced 0 that cycle.
  - `done` pulses the next cycle.
- Reset: `psum_ready`, `ac_in_en`, `ac_F`, `out_valid`, `busy` and `done` are all 0. Counters, `first_d` and `started` are 0, and the state is IDLE. Reset mid-run abandons the partial sum without producing a `done`.
- Arithmetic (width of the sum) is entirely inside AC. The controller is width-agnostic.

## Timing
- Accept at cycle k → AC `ipsum_reg` loaded at edge k → sum visible on AC `data_out` in k+1.
- Last term accepted at cycle k → `out_valid` = 1 in k+1. Result latency is therefore 1 cycle after the final accept.
- Peak throughput: one psum per cycle. One output per N cycles, with zero bubbles between outputs when `out_ready` = 1.
- A stalled output (`out_ready` = 0) blocks new psums; `data_out` stays stable because F = 1 and `in_en` = 0.
- `cfg_start` in RUN has no effect. `cfg_start` in the same cycle as `rst` loses to `rst`.

## Structure
- `ac_pkg` contains:
  - the state enum (IDLE, RUN);
  - the default `CNT_WIDTH`;
  - the tile-config struct {num_terms, num_outputs}.
- One natural sub-module: `wrap_counter`, a loadable up-counter with clear, increment and terminal-count flag. It is instantiated for `term_cnt` and `out_cnt`.
- Benches instantiate ac_ctrl with AC for end-to-end checks. AC's active-low reset is driven as `~rst`.

## Test plan
- N=3, M=2, psums 1,2,3,10,20,30 back-to-back, `out_ready`=1 → outputs 6 then 60. `out_valid` one cycle after the 3rd and 6th accepts. `done` one cycle after the second `out_fire`.
- N=4, M=1, `psum_valid` toggled 1,0,1,0,… with values 5,6,7,8 → output 26. F = 0 only in the cycle after accepting 5.
- N=2, M=2, `out_ready` held 0 for 5 cycles after the first result 3+4 → `data_out` stays 7, `psum_ready` = 0 throughout. Then the second output is 9+1 = 10.
- N=1, M=4, values 7,8,9,10 streaming, `out_ready`=1 → four outputs equal to the inputs on consecutive cycles, `psum_ready` continuously 1.
- `cfg_num_terms`=0, M=0 → `done` pulses next cycle with no transfers. A subsequent N=0, M=1 behaves as N=1.
- `rst` asserted after 2 of 3 terms, then a new run with N=2, M=1 and values 4,5 → output 9, no leftover value.

Source files
------------

// File: rtl/ac_pkg.sv
// Shared types for the accumulator sequencing controller.
// Holds the FSM state type, default counter width and tile config.
package ac_pkg;

   localparam int CNT_WIDTH_DEF = 16;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [CNT_WIDTH_DEF-1:0] num_terms;
      logic [CNT_WIDTH_DEF-1:0] num_outputs;
   } tile_cfg_t;

endpackage

// File: rtl/ac_wrap_counter.sv
// Loadable up-counter with clear and a terminal-count compare flag.
// Ports: clk, rst, clr, load/load_val, inc, tc_val -> cnt, tc.
module wrap_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic [W-1:0] tc_val,
   output logic [W-1:0] cnt,
   output logic         tc
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (inc) begin
         cnt <= cnt + W'(1);
      end
   end

   assign tc = (cnt == tc_val);

endmodule

// File: rtl/ac_ctrl.sv
// Sequencer folding every N psums into one AC result per output.
// Ports: cfg_*, psum valid/ready, ac_in_en/ac_F, out valid/ready, busy, done.
module ac_ctrl
   import ac_pkg::*;
#(
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_start,
   input  logic [CNT_WIDTH-1:0] cfg_num_terms,
   input  logic [CNT_WIDTH-1:0] cfg_num_outputs,
   input  logic                 psum_valid,
   output logic                 psum_ready,
   output logic                 ac_in_en,
   output logic                 ac_F,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 done
);

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   state_t               state;
   logic [CNT_WIDTH-1:0] n_reg;
   logic [CNT_WIDTH-1:0] m_reg;
   logic [CNT_WIDTH-1:0] term_cnt;
   logic [CNT_WIDTH-1:0] out_cnt_unused;
   logic                 term_full;
   logic                 out_last;
   logic                 out_fire;
   logic                 last_fire;
   logic                 accept;
   logic                 start;
   logic                 first;
   logic                 set_valid;
   logic                 first_d;
   logic                 started;

   assign busy      = (state == RUN);
   assign start     = cfg_start & ~busy;
   assign out_fire  = out_valid & out_ready;
   assign last_fire = out_fire & out_last;

   // A full term count only frees up when its result leaves this cycle.
   assign psum_ready = busy & ~last_fire & (~term_full | out_fire);
   assign accept     = psum_valid & psum_ready;
   assign ac_in_en   = accept;
   assign ac_F       = started;

   assign first = accept & ((term_cnt == '0) | out_fire);

   // On a restart the counter reloads to 1, so only N=1 completes at once.
   assign set_valid = accept & (out_fire ? (n_reg == ONE)
                                         : (term_cnt == n_reg - ONE));

   wrap_counter #(.W(CNT_WIDTH)) u_term_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (start),
      .load     (out_fire),
      .load_val ({{(CNT_WIDTH-1){1'b0}}, accept}),
      .inc      (accept),
      .tc_val   (n_reg),
      .cnt      (term_cnt),
      .tc       (term_full)
   );

   wrap_counter #(.W(CNT_WIDTH)) u_out_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (start),
      .load     (1'b0),
      .load_val ('0),
      .inc      (out_fire),
      .tc_val   (m_reg - ONE),
      .cnt      (out_cnt_unused),
      .tc       (out_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         n_reg     <= '0;
         m_reg     <= '0;
         out_valid <= 1'b0;
         first_d   <= 1'b0;
         started   <= 1'b0;
         done      <= 1'b0;
      end else begin
         done      <= 1'b0;
         first_d   <= first;
         // F stays low for exactly the cycle the first term hits the adder.
         started   <= (started | first_d) & ~out_fire;
         out_valid <= (out_valid & ~out_fire) | set_valid;
         if (start) begin
            n_reg <= (cfg_num_terms == '0) ? ONE : cfg_num_terms;
            m_reg <= cfg_num_outputs;
            if (cfg_num_outputs == '0) begin
               done <= 1'b1;
            end else begin
               state <= RUN;
            end
         end else if (last_fire) begin
            state <= IDLE;
            done  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ac_ctrl.sv
// Bench for ac_ctrl driving a behavioural AC datapath.
// Results are compared against group sums of the psum stream.
module tb_ac_ctrl;
   import ac_pkg::*;

   localparam int W = CNT_WIDTH_DEF;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cfg_start = 1'b0;
   logic [W-1:0] cfg_num_terms = '0;
   logic [W-1:0] cfg_num_outputs = '0;
   logic         psum_valid = 1'b0;
   logic         psum_ready;
   logic         ac_in_en;
   logic         ac_F;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         busy;
   logic         done;

   logic [31:0]  ipsum = '0;
   logic [31:0]  ipsum_reg;
   logic [31:0]  psum_reg;
   logic [31:0]  data_out;
   logic         ac_rst_n;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int got_sum[$];
   int got_cyc[$];
   int acc_cyc[$];
   int f0_cyc[$];
   int stall_data[$];
   int stall_rdy;
   int rdy_low;
   int fires;
   int done_at;
   bit timed_out;
   bit done_seen;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // AC: registered input stage, adder folding into psum_reg when F=1.
   assign ac_rst_n = ~rst;
   always @(posedge clk) begin
      if (!ac_rst_n) begin
         ipsum_reg <= '0;
         psum_reg  <= '0;
      end else begin
         ipsum_reg <= ac_in_en ? ipsum : 32'd0;
         psum_reg  <= data_out;
      end
   end
   assign data_out = (ac_F ? psum_reg : 32'd0) + ipsum_reg;

   ac_ctrl #(.CNT_WIDTH(W)) dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_start       (cfg_start),
      .cfg_num_terms   (cfg_num_terms),
      .cfg_num_outputs (cfg_num_outputs),
      .psum_valid      (psum_valid),
      .psum_ready      (psum_ready),
      .ac_in_en        (ac_in_en),
      .ac_F            (ac_F),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .busy            (busy),
      .done            (done)
   );

   task automatic start_cfg(input int n, input int m,
                            output bit d, output bit b);
      @(posedge clk); #1;
      cfg_start       = 1'b1;
      cfg_num_terms   = W'(n);
      cfg_num_outputs = W'(m);
      @(negedge clk);
      @(posedge clk); #1;
      cfg_start = 1'b0;
      @(negedge clk);
      d = done;
      b = busy;
   endtask

   task automatic run(input int vals[$], input bit tog,
                      input int vprob, input int rprob,
                      input int stall_idx, input int stall_len,
                      input int budget);
      int vq[$];
      int stall_left;
      bit ph;
      int it;
      vq = vals;
      stall_left = stall_len;
      ph = 1'b1;
      it = 0;
      got_sum.delete(); got_cyc.delete(); acc_cyc.delete();
      f0_cyc.delete(); stall_data.delete();
      stall_rdy = 0; rdy_low = 0; fires = 0; done_at = -1;
      timed_out = 1'b0; done_seen = 1'b0;
      while (!done_seen && !timed_out) begin
         @(posedge clk); #1;
         psum_valid = (vq.size() > 0) &&
                      (tog ? ph : ($urandom_range(99) < vprob));
         ipsum = (vq.size() > 0) ? 32'(vq[0]) : 32'd0;
         ph = !ph;
         if (out_valid && fires == stall_idx && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = ($urandom_range(99) < rprob);
         end
         @(negedge clk);
         if (busy && !ac_F && acc_cyc.size() > 0) f0_cyc.push_back(cyc);
         if (out_valid && !out_ready && fires == stall_idx) begin
            stall_data.push_back(int'(data_out));
            if (psum_ready) stall_rdy++;
         end
         if (busy && psum_valid && !psum_ready) rdy_low++;
         if (ac_in_en) begin
            acc_cyc.push_back(cyc);
            void'(vq.pop_front());
         end
         if (out_valid && out_ready) begin
            got_sum.push_back(int'(data_out));
            got_cyc.push_back(cyc);
            fires++;
         end
         if (done) begin
            done_seen = 1'b1;
            done_at = cyc;
         end
         it++;
         if (it >= budget) timed_out = 1'b1;
      end
      psum_valid = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      cfg_start = 1'b1;
      cfg_num_terms = W'(2);
      cfg_num_outputs = W'(3);
      psum_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (psum_ready !== 1'b0) begin errors++;
         $display("FAIL reset_psum_ready got %b exp 0", psum_ready); end
      checks++; if (ac_in_en !== 1'b0) begin errors++;
         $display("FAIL reset_in_en got %b exp 0", ac_in_en); end
      checks++; if (ac_F !== 1'b0) begin errors++;
         $display("FAIL reset_F got %b exp 0", ac_F); end
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++;
         $display("FAIL reset_done got %b exp 0", done); end
      @(posedge clk); #1;
      rst = 1'b0;
      cfg_start = 1'b0;
      psum_valid = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
         $display("FAIL start_vs_rst got busy %b done %b exp 0 0",
                  busy, done); end
   endtask

   task automatic test_back_to_back();
      bit d, b;
      int v[$];
      v = '{1, 2, 3, 10, 20, 30};
      start_cfg(3, 2, d, b);
      run(v, 1'b0, 100, 100, -1, 0, 200);
      checks++; if (timed_out || got_sum.size() != 2 || acc_cyc.size() != 6)
      begin errors++;
         $display("FAIL b2b_count got %0d outs %0d accepts exp 2 6",
                  got_sum.size(), acc_cyc.size());
      end else begin
         checks++; if (got_sum[0] != 6 || got_sum[1] != 60) begin errors++;
            $display("FAIL b2b_sums got %0d %0d exp 6 60",
                     got_sum[0], got_sum[1]); end
         checks++; if (got_cyc[0] != acc_cyc[2] + 1 ||
                       got_cyc[1] != acc_cyc[5] + 1) begin errors++;
            $display("FAIL b2b_latency got %0d %0d exp %0d %0d",
                     got_cyc[0], got_cyc[1], acc_cyc[2] + 1, acc_cyc[5] + 1);
         end
         checks++; if (acc_cyc[5] - acc_cyc[0] != 5) begin errors++;
            $display("FAIL b2b_bubbles got span %0d exp 5",
                     acc_cyc[5] - acc_cyc[0]); end
         checks++; if (done_at != got_cyc[1] + 1) begin errors++;
            $display("FAIL b2b_done got %0d exp %0d",
                     done_at, got_cyc[1] + 1); end
      end
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL b2b_idle got busy %b exp 0", busy); end
   endtask

   task automatic test_toggle();
      bit d, b;
      int v[$];
      v = '{5, 6, 7, 8};
      start_cfg(4, 1, d, b);
      run(v, 1'b1, 0, 100, -1, 0, 200);
      checks++; if (timed_out || got_sum.size() != 1 || acc_cyc.size() != 4)
      begin errors++;
         $display("FAIL tog_count got %0d outs exp 1", got_sum.size());
      end else begin
         checks++; if (got_sum[0] != 26) begin errors++;
            $display("FAIL tog_sum got %0d exp 26", got_sum[0]); end
         checks++; if (f0_cyc.size() != 1 || f0_cyc[0] != acc_cyc[0] + 1)
         begin errors++;
            $display("FAIL tog_F0 got %0d low cycles exp 1 at %0d",
                     f0_cyc.size(), acc_cyc[0] + 1); end
         checks++; if (acc_cyc[3] - acc_cyc[0] != 6) begin errors++;
            $display("FAIL tog_spacing got %0d exp 6",
                     acc_cyc[3] - acc_cyc[0]); end
      end
   endtask

   task automatic test_stall();
      bit d, b;
      int v[$];
      int bad;
      v = '{3, 4, 9, 1};
      start_cfg(2, 2, d, b);
      run(v, 1'b0, 100, 100, 0, 5, 200);
      bad = 0;
      foreach (stall_data[i]) if (stall_data[i] != 7) bad++;
      checks++; if (stall_data.size() != 5 || bad != 0) begin errors++;
         $display("FAIL stall_hold got %0d cycles %0d wrong exp 5 0",
                  stall_data.size(), bad); end
      checks++; if (stall_rdy != 0) begin errors++;
         $display("FAIL stall_ready got %0d ready cycles exp 0", stall_rdy);
      end
      checks++; if (timed_out || got_sum.size() != 2) begin errors++;
         $display("FAIL stall_count got %0d exp 2", got_sum.size());
      end else begin
         checks++; if (got_sum[0] != 7 || got_sum[1] != 10) begin errors++;
            $display("FAIL stall_sums got %0d %0d exp 7 10",
                     got_sum[0], got_sum[1]); end
      end
   endtask

   task automatic test_n1();
      bit d, b;
      int v[$];
      v = '{7, 8, 9, 10};
      start_cfg(1, 4, d, b);
      run(v, 1'b0, 100, 100, -1, 0, 200);
      checks++; if (timed_out || got_sum.size() != 4) begin errors++;
         $display("FAIL n1_count got %0d exp 4", got_sum.size());
      end else begin
         foreach (v[i]) begin
            checks++; if (got_sum[i] != v[i]) begin errors++;
               $display("FAIL n1_out%0d got %0d exp %0d",
                        i, got_sum[i], v[i]); end
         end
         checks++; if (got_cyc[3] - got_cyc[0] != 3) begin errors++;
            $display("FAIL n1_consec got %0d exp 3", got_cyc[3] - got_cyc[0]);
         end
      end
      checks++; if (rdy_low != 0) begin errors++;
         $display("FAIL n1_ready got %0d low cycles exp 0", rdy_low); end
   endtask

   task automatic test_zero();
      bit d, b;
      int v[$];
      start_cfg(0, 0, d, b);
      checks++; if (d !== 1'b1 || b !== 1'b0) begin errors++;
         $display("FAIL zero_done got done %b busy %b exp 1 0", d, b); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++;
         $display("FAIL zero_pulse got %b exp 0", done); end
      v = '{42};
      start_cfg(0, 1, d, b);
      run(v, 1'b0, 100, 100, -1, 0, 100);
      checks++; if (timed_out || got_sum.size() != 1) begin errors++;
         $display("FAIL n0_count got %0d exp 1", got_sum.size());
      end else begin
         checks++; if (got_sum[0] != 42 || got_cyc[0] != acc_cyc[0] + 1)
         begin errors++;
            $display("FAIL n0_out got %0d at %0d exp 42 at %0d",
                     got_sum[0], got_cyc[0], acc_cyc[0] + 1); end
      end
   endtask

   task automatic test_reset_mid();
      bit d, b;
      int v[$];
      int dn;
      v = '{11, 12};
      start_cfg(3, 1, d, b);
      run(v, 1'b0, 100, 100, -1, 0, 6);
      checks++; if (acc_cyc.size() != 2 || got_sum.size() != 0) begin
         errors++;
         $display("FAIL mid_partial got %0d acc %0d outs exp 2 0",
                  acc_cyc.size(), got_sum.size()); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || ac_F !== 1'b0)
      begin errors++;
         $display("FAIL mid_rst got busy %b ov %b F %b exp 0 0 0",
                  busy, out_valid, ac_F); end
      dn = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) dn++;
      end
      checks++; if (dn != 0) begin errors++;
         $display("FAIL mid_no_done got %0d pulses exp 0", dn); end
      v = '{4, 5};
      start_cfg(2, 1, d, b);
      run(v, 1'b0, 100, 100, -1, 0, 100);
      checks++; if (timed_out || got_sum.size() != 1) begin errors++;
         $display("FAIL mid_count got %0d exp 1", got_sum.size());
      end else begin
         checks++; if (got_sum[0] != 9) begin errors++;
            $display("FAIL mid_sum got %0d exp 9", got_sum[0]); end
      end
   endtask

   task automatic test_random();
      tile_cfg_t cfg;
      bit d, b;
      int v[$];
      int exp_s[$];
      int neff;
      int s;
      for (int t = 0; t < 8; t++) begin
         cfg.num_terms   = W'($urandom_range(0, 5));
         cfg.num_outputs = W'($urandom_range(0, 3));
         neff = (cfg.num_terms == '0) ? 1 : int'(cfg.num_terms);
         v.delete();
         exp_s.delete();
         for (int o = 0; o < int'(cfg.num_outputs); o++) begin
            s = 0;
            for (int k = 0; k < neff; k++) begin
               v.push_back(int'($urandom_range(0, 1000)));
               s += v[v.size() - 1];
            end
            exp_s.push_back(s);
         end
         start_cfg(int'(cfg.num_terms), int'(cfg.num_outputs), d, b);
         if (cfg.num_outputs == '0) begin
            checks++; if (d !== 1'b1 || b !== 1'b0) begin errors++;
               $display("FAIL rnd%0d_m0 got done %b busy %b exp 1 0",
                        t, d, b); end
         end else begin
            run(v, 1'b0, int'($urandom_range(40, 100)),
                int'($urandom_range(30, 100)), -1, 0, 2000);
            checks++; if (timed_out || got_sum.size() != exp_s.size())
            begin errors++;
               $display("FAIL rnd%0d_count got %0d exp %0d",
                        t, got_sum.size(), exp_s.size());
            end else begin
               foreach (exp_s[i]) begin
                  checks++; if (got_sum[i] != exp_s[i]) begin errors++;
                     $display("FAIL rnd%0d_out%0d got %0d exp %0d",
                              t, i, got_sum[i], exp_s[i]); end
               end
            end
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_back_to_back();
      test_toggle();
      test_stall();
      test_n1();
      test_zero();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
